// File: rtl/ram_arb.sv
// Single-port RAM arbiter between IFU reads and LSU loads/stores. Reads respond RD_LAT cycles after grant.
// No response backpressure. Define RAM_ARB_RR_EN for round-robin instead of LSU priority with starvation override.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module ram_arb #(
  parameter int ADDR_W     = `ADDR_WIDTH,
  parameter int DATA_W     = `DATA_WIDTH,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ifu_req_valid,
  output logic                o_ifu_req_ready,
  input  logic [ADDR_W-1:0]   i_ifu_req_addr,
  output logic                o_ifu_resp_valid,
  output logic [DATA_W-1:0]   o_ifu_resp_data,
  input  logic                i_lsu_req_valid,
  output logic                o_lsu_req_ready,
  input  logic                i_lsu_req_wr_en,
  input  logic [ADDR_W-1:0]   i_lsu_req_addr,
  input  logic [DATA_W-1:0]   i_lsu_req_wr_data,
  input  logic [DATA_W/8-1:0] i_lsu_req_wr_mask,
  output logic                o_lsu_resp_valid,
  output logic [DATA_W-1:0]   o_lsu_resp_data,
  output logic                o_ram_rd_en,
  output logic [ADDR_W-1:0]   o_ram_rd_addr,
  input  logic [DATA_W-1:0]   i_ram_rd_data,
  output logic                o_ram_wr_en,
  output logic [ADDR_W-1:0]   o_ram_wr_addr,
  output logic [DATA_W-1:0]   o_ram_wr_data,
  output logic [DATA_W/8-1:0] o_ram_wr_mask
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_RESP} state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  state_t     state;
  logic [2:0] lat_cnt;
  logic       owner_vld;
  logic       owner_lsu;
`ifdef RAM_ARB_RR_EN
  logic       last_grant_lsu;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;
`endif

  logic idle, lsu_pick, lsu_gnt, ifu_gnt, lsu_rd_gnt, lsu_wr_gnt, rd_done, lsu_rd_done;

  // Reset gates every output so nothing leaks while i_rst_n is low.
  assign idle = i_rst_n && (state == IDLE);
`ifdef RAM_ARB_RR_EN
  assign lsu_pick = i_lsu_req_valid && (!i_ifu_req_valid || !last_grant_lsu);
`else
  assign lsu_pick = i_lsu_req_valid && ((starve_cnt < STARVE_LIM) || !i_ifu_req_valid);
`endif
  assign lsu_gnt    = idle && lsu_pick;
  assign ifu_gnt    = idle && i_ifu_req_valid && !lsu_pick;
  assign lsu_rd_gnt = lsu_gnt && !i_lsu_req_wr_en;
  assign lsu_wr_gnt = lsu_gnt && i_lsu_req_wr_en;

  assign o_ifu_req_ready = ifu_gnt;
  assign o_lsu_req_ready = lsu_gnt;

  assign o_ram_rd_en   = ifu_gnt || lsu_rd_gnt;
  assign o_ram_rd_addr = ifu_gnt ? i_ifu_req_addr : (lsu_rd_gnt ? i_lsu_req_addr : '0);
  assign o_ram_wr_en   = lsu_wr_gnt;
  assign o_ram_wr_addr = lsu_wr_gnt ? i_lsu_req_addr : '0;
  assign o_ram_wr_data = lsu_wr_gnt ? i_lsu_req_wr_data : '0;
  assign o_ram_wr_mask = lsu_wr_gnt ? i_lsu_req_wr_mask : '0;

  assign rd_done     = i_rst_n && (state == RD_WAIT) && (lat_cnt == 3'd1) && owner_vld;
  assign lsu_rd_done = rd_done && owner_lsu;

  assign o_ifu_resp_valid = rd_done && !owner_lsu;
  assign o_ifu_resp_data  = o_ifu_resp_valid ? i_ram_rd_data : '0;
  assign o_lsu_resp_valid = lsu_rd_done || (i_rst_n && (state == WR_RESP));
  assign o_lsu_resp_data  = lsu_rd_done ? i_ram_rd_data : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      lat_cnt   <= 3'd0;
      owner_vld <= 1'b0;
      owner_lsu <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last_grant_lsu <= 1'b0;
`else
      starve_cnt <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ifu_gnt || lsu_rd_gnt) begin
            state     <= RD_WAIT;
            lat_cnt   <= LAT_INIT;
            owner_vld <= 1'b1;
            owner_lsu <= lsu_rd_gnt;
          end else if (lsu_wr_gnt) begin
            state <= WR_RESP;
          end
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            state     <= IDLE;
            owner_vld <= 1'b0;
          end
        end
        WR_RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef RAM_ARB_RR_EN
      if (ifu_gnt)
        last_grant_lsu <= 1'b0;
      else if (lsu_gnt)
        last_grant_lsu <= 1'b1;
`else
      // Count IFU losses only; saturate so the override stays latched until the IFU wins.
      if (ifu_gnt)
        starve_cnt <= 4'd0;
      else if (lsu_gnt && i_ifu_req_valid && (starve_cnt < STARVE_LIM))
        starve_cnt <= starve_cnt + 4'd1;
`endif
    end
  end

endmodule
